draw_playfield: RTL and testbench
=================================

DRAW_PLAYFIELD -- requirements
Module: draw_playfield

Interface
REQ-001 Parameter HOR_PIX, 1024, visible pixels per line.
REQ-002 Parameter VER_PIX, 768, visible lines per frame.
REQ-003 Parameter GRID_SIZE, 16, cell edge in pixels; power of two, 4..64.
REQ-004 Parameter FRAME_X_SIZE, 40, outer frame width in cells.
REQ-005 Parameter FRAME_Y_SIZE, 20, outer frame height in cells.
REQ-006 Parameter FRAME_WIDTH, 1, border thickness in cells; at least 1.
REQ-007 Parameters BG_COLOR 12'hfff, FRAME_COLOR 12'hff0, FLASH_COLOR 12'hf00, GRID_COLOR 12'h00f; 12-bit RGB 4:4:4.
REQ-008 Parameter FLASH_FRAMES, 30, frames per flash phase; at least 1.
REQ-009 Clock and reset: one clock, pclk, all state updates on its rising edge; rst is synchronous and active-high.
REQ-010 Port pclk, in, 1: pixel clock.
REQ-011 Port rst, in, 1: synchronous active-high reset.
REQ-012 Ports hcount_in, vcount_in, in, 11 each: pixel position.
REQ-013 Ports hsync_in, hblnk_in, vsync_in, vblnk_in, in, 1 each: timing signals.
REQ-014 Port grid_en, in, 1: enables the grid-line overlay.
REQ-015 Port flash_en, in, 1: enables border flashing.
REQ-016 Ports hcount_out, vcount_out (11 bits) and hsync_out, hblnk_out, vsync_out, vblnk_out (1 bit each), out: delayed timing.
REQ-017 Port rgb_out, out, 12: pixel colour.
REQ-018 Ports cell_x, cell_y, out, 10 each: absolute cell index of the output pixel.
REQ-019 Port in_play, out, 1: output pixel lies in the frame interior.
REQ-020 Port frame_start, out, 1: one-cycle pulse on a rising edge of vblnk_in.
REQ-021 Ports play_x0_grid, play_y0_grid, play_w_grid, play_h_grid, out, 10 each: constant interior origin and size in cells.

Function
REQ-022 Geometry:
- X0 = (HOR_PIX - FRAME_X_SIZE*GRID_SIZE)/2; Y0 likewise using VER_PIX and FRAME_Y_SIZE.
- Outer rectangle: X0 <= h < X0 + FRAME_X_SIZE*GRID_SIZE, with the matching Y range.
- Inner rectangle: outer rectangle inset by FRAME_WIDTH*GRID_SIZE on all four sides.
REQ-023 Two-stage pipeline: every output, including rgb_out, cell_x, cell_y, in_play and the timing outputs, appears exactly 2 pclk cycles after the corresponding input sample.
REQ-024 Colour priority, highest first:
- Blanking (hblnk_in or vblnk_in) -> 12'h000.
- Pixel in outer but not inner rectangle -> border colour (REQ-027).
- Pixel in inner rectangle, grid_en=1, and h%GRID_SIZE==0 or v%GRID_SIZE==0 -> GRID_COLOR.
- Otherwise -> BG_COLOR.
REQ-025 cell_x = hcount>>log2(GRID_SIZE) and cell_y = vcount>>log2(GRID_SIZE), zero-extended to 10 bits; no dividers. in_play = inner-rectangle membership, forced to 0 during blanking.
REQ-026 frame_start: registered vblnk_in is compared with the current vblnk_in; the pulse appears on the cycle after the rising edge; no pulse is produced by reset release.
REQ-027 Flash FSM, states IDLE, LIT, DARK, with a frame counter of clog2(FLASH_FRAMES)+1 bits:
- IDLE: border = FRAME_COLOR; flash_en=1 and frame_start -> LIT, counter = 0.
- LIT: border = FLASH_COLOR. DARK: border = BG_COLOR.
- In LIT or DARK, each frame_start increments the counter; at FLASH_FRAMES-1 the state toggles LIT<->DARK and the counter clears.
- flash_en=0 in any state -> IDLE on the next cycle with counter = 0; this overrides a simultaneous frame_start.
REQ-028 A state change takes effect at the next pixel through the pipeline; mid-frame changes are permitted.
REQ-029 play_x0_grid = X0/GRID_SIZE + FRAME_WIDTH; play_y0_grid likewise; play_w_grid = FRAME_X_SIZE - 2*FRAME_WIDTH; play_h_grid = FRAME_Y_SIZE - 2*FRAME_WIDTH; all combinational constants.

Reset
REQ-030 While rst=1 at a pclk edge, the following clear to 0: all pipeline registers, every timing output, rgb_out, cell_x, cell_y, in_play, frame_start, the FSM (to IDLE), the frame counter, and the registered vblnk.
REQ-031 Reset asserted mid-flash returns to IDLE; flashing restarts only at the first frame_start after release with flash_en=1.

Verification
REQ-032 Defaults; pixel (192,300), no blanking, flash_en=0 -> 2 cycles later rgb_out=12'hff0, in_play=0, cell=(12,18).
REQ-033 Pixel (500,400) with grid_en=1 -> 12'h00f, in_play=1, cell=(31,25). Same pixel with grid_en=0 -> 12'hfff. Pixel (500,401) with grid_en=1 -> 12'hfff.
REQ-034 Pixel (500,400) with hblnk_in=1 -> 12'h000, in_play=0; hsync_in, hblnk_in and hcount_in appear on the outputs 2 cycles later, unchanged.
REQ-035 FLASH_FRAMES=2, flash_en=1, then 5 vblnk rising edges -> border sequence FRAME_COLOR, LIT after edge 1, DARK after edge 3, LIT after edge 5; dropping flash_en -> 12'hff0 at pixel (192,300) 3 cycles later.
REQ-036 Assert rst while in DARK, then release with vblnk_in held high -> frame_start stays 0, state IDLE, all outputs 0 during reset; play_x0_grid=13, play_y0_grid=15, play_w_grid=38, play_h_grid=18 at all times.

Source files
------------

// File: rtl/draw_playfield.sv
// draw_playfield
// Paints a framed playfield onto the incoming video timing stream. The
// frame border can flash between two colours, and a grid overlay can be
// drawn inside the frame. Each output is delayed by exactly two pclk cycles
// from its input sample.
//
// Ports
//   pclk, rst                   pixel clock, synchronous active-high reset
//   hcount_in, vcount_in        pixel position (11 bits)
//   hsync/hblnk/vsync/vblnk_in  timing signals
//   grid_en, flash_en           overlay and border-flash enables
//   *_out                       timing signals delayed by two cycles
//   rgb_out                     pixel colour, RGB 4:4:4
//   cell_x, cell_y              absolute cell index of the output pixel
//   in_play                     output pixel lies in the frame interior
//   frame_start                 one-cycle pulse after a rising edge of vblnk_in
//   play_*_grid                 constant interior origin and size, in cells
//
// Flash FSM
//   state | meaning
//   IDLE  | border drawn in FRAME_COLOR, waiting for flash_en and frame_start
//   LIT   | border drawn in FLASH_COLOR
//   DARK  | border drawn in BG_COLOR
module draw_playfield #(
  parameter int          HOR_PIX      = 1024,
  parameter int          VER_PIX      = 768,
  parameter int          GRID_SIZE    = 16,
  parameter int          FRAME_X_SIZE = 40,
  parameter int          FRAME_Y_SIZE = 20,
  parameter int          FRAME_WIDTH  = 1,
  parameter logic [11:0] BG_COLOR     = 12'hfff,
  parameter logic [11:0] FRAME_COLOR  = 12'hff0,
  parameter logic [11:0] FLASH_COLOR  = 12'hf00,
  parameter logic [11:0] GRID_COLOR   = 12'h00f,
  parameter int          FLASH_FRAMES = 30
) (
  input  logic        pclk,
  input  logic        rst,
  input  logic [10:0] hcount_in,
  input  logic [10:0] vcount_in,
  input  logic        hsync_in,
  input  logic        hblnk_in,
  input  logic        vsync_in,
  input  logic        vblnk_in,
  input  logic        grid_en,
  input  logic        flash_en,
  output logic [10:0] hcount_out,
  output logic [10:0] vcount_out,
  output logic        hsync_out,
  output logic        hblnk_out,
  output logic        vsync_out,
  output logic        vblnk_out,
  output logic [11:0] rgb_out,
  output logic [9:0]  cell_x,
  output logic [9:0]  cell_y,
  output logic        in_play,
  output logic        frame_start,
  output logic [9:0]  play_x0_grid,
  output logic [9:0]  play_y0_grid,
  output logic [9:0]  play_w_grid,
  output logic [9:0]  play_h_grid
);

  localparam int LOG2G = $clog2(GRID_SIZE);
  localparam int X0    = (HOR_PIX - FRAME_X_SIZE * GRID_SIZE) / 2;
  localparam int Y0    = (VER_PIX - FRAME_Y_SIZE * GRID_SIZE) / 2;
  localparam int INSET = FRAME_WIDTH * GRID_SIZE;

  localparam logic [10:0] OUT_X_LO = 11'(X0);
  localparam logic [10:0] OUT_X_HI = 11'(X0 + FRAME_X_SIZE * GRID_SIZE);
  localparam logic [10:0] OUT_Y_LO = 11'(Y0);
  localparam logic [10:0] OUT_Y_HI = 11'(Y0 + FRAME_Y_SIZE * GRID_SIZE);
  localparam logic [10:0] IN_X_LO  = 11'(X0 + INSET);
  localparam logic [10:0] IN_X_HI  = 11'(X0 + FRAME_X_SIZE * GRID_SIZE - INSET);
  localparam logic [10:0] IN_Y_LO  = 11'(Y0 + INSET);
  localparam logic [10:0] IN_Y_HI  = 11'(Y0 + FRAME_Y_SIZE * GRID_SIZE - INSET);

  localparam int CNT_W = $clog2(FLASH_FRAMES) + 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(FLASH_FRAMES - 1);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] LIT  = 2'd1;
  localparam logic [1:0] DARK = 2'd2;

  assign play_x0_grid = 10'(X0 / GRID_SIZE + FRAME_WIDTH);
  assign play_y0_grid = 10'(Y0 / GRID_SIZE + FRAME_WIDTH);
  assign play_w_grid  = 10'(FRAME_X_SIZE - 2 * FRAME_WIDTH);
  assign play_h_grid  = 10'(FRAME_Y_SIZE - 2 * FRAME_WIDTH);

  // Stage 1 geometry decode
  logic in_outer, in_inner, on_grid;

  assign in_outer = (hcount_in >= OUT_X_LO) && (hcount_in < OUT_X_HI) &&
                    (vcount_in >= OUT_Y_LO) && (vcount_in < OUT_Y_HI);
  assign in_inner = (hcount_in >= IN_X_LO) && (hcount_in < IN_X_HI) &&
                    (vcount_in >= IN_Y_LO) && (vcount_in < IN_Y_HI);
  assign on_grid  = (hcount_in[LOG2G-1:0] == '0) || (vcount_in[LOG2G-1:0] == '0);

  logic [10:0] h1, v1;
  logic        hs1, hb1, vs1, vb1;
  logic        blank1, outer1, inner1, grid1;
  logic [9:0]  cx1, cy1;

  always_ff @(posedge pclk) begin
    if (rst) begin
      h1 <= '0; v1 <= '0;
      hs1 <= 1'b0; hb1 <= 1'b0; vs1 <= 1'b0; vb1 <= 1'b0;
      blank1 <= 1'b0; outer1 <= 1'b0; inner1 <= 1'b0; grid1 <= 1'b0;
      cx1 <= '0; cy1 <= '0;
    end else begin
      h1 <= hcount_in; v1 <= vcount_in;
      hs1 <= hsync_in; hb1 <= hblnk_in; vs1 <= vsync_in; vb1 <= vblnk_in;
      blank1 <= hblnk_in | vblnk_in;
      outer1 <= in_outer;
      inner1 <= in_inner;
      grid1  <= on_grid & grid_en;
      cx1    <= 10'(hcount_in >> LOG2G);
      cy1    <= 10'(vcount_in >> LOG2G);
    end
  end

  // Frame-start detection. vblnk_vld keeps the first cycle after reset from
  // seeing a cleared vblnk_q against a high vblnk_in as a rising edge.
  logic vblnk_q, vblnk_vld;

  always_ff @(posedge pclk) begin
    if (rst) begin
      vblnk_q     <= 1'b0;
      vblnk_vld   <= 1'b0;
      frame_start <= 1'b0;
    end else begin
      vblnk_q     <= vblnk_in;
      vblnk_vld   <= 1'b1;
      frame_start <= vblnk_vld & vblnk_in & ~vblnk_q;
    end
  end

  // Flash FSM; flash_en low wins over a simultaneous frame_start.
  logic [1:0]       state;
  logic [CNT_W-1:0] cnt;

  always_ff @(posedge pclk) begin
    if (rst || !flash_en) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      case (state)
        IDLE: if (frame_start) begin
          state <= LIT;
          cnt   <= '0;
        end
        LIT, DARK: if (frame_start) begin
          if (cnt == CNT_LAST) begin
            state <= (state == LIT) ? DARK : LIT;
            cnt   <= '0;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: begin
          state <= IDLE;
          cnt   <= '0;
        end
      endcase
    end
  end

  logic [11:0] border;

  always_comb begin
    border = FRAME_COLOR;
    case (state)
      LIT:     border = FLASH_COLOR;
      DARK:    border = BG_COLOR;
      default: border = FRAME_COLOR;
    endcase
  end

  // Stage 2: colour select uses the live FSM state so a change shows up on
  // the next pixel leaving the pipeline.
  always_ff @(posedge pclk) begin
    if (rst) begin
      hcount_out <= '0; vcount_out <= '0;
      hsync_out <= 1'b0; hblnk_out <= 1'b0; vsync_out <= 1'b0; vblnk_out <= 1'b0;
      rgb_out <= '0; cell_x <= '0; cell_y <= '0; in_play <= 1'b0;
    end else begin
      hcount_out <= h1; vcount_out <= v1;
      hsync_out <= hs1; hblnk_out <= hb1; vsync_out <= vs1; vblnk_out <= vb1;
      cell_x  <= cx1;
      cell_y  <= cy1;
      in_play <= inner1 & ~blank1;
      if (blank1)                rgb_out <= 12'h000;
      else if (outer1 && !inner1) rgb_out <= border;
      else if (inner1 && grid1)   rgb_out <= GRID_COLOR;
      else                        rgb_out <= BG_COLOR;
    end
  end

endmodule

// File: tb/tb_draw_playfield.sv
// Directed testbench for draw_playfield (FLASH_FRAMES overridden to 2).
module tb_draw_playfield;

  logic        pclk = 1'b0;
  logic        rst;
  logic [10:0] hcount_in, vcount_in;
  logic        hsync_in, hblnk_in, vsync_in, vblnk_in;
  logic        grid_en, flash_en;
  logic [10:0] hcount_out, vcount_out;
  logic        hsync_out, hblnk_out, vsync_out, vblnk_out;
  logic [11:0] rgb_out;
  logic [9:0]  cell_x, cell_y;
  logic        in_play, frame_start;
  logic [9:0]  play_x0_grid, play_y0_grid, play_w_grid, play_h_grid;

  int n_checks = 0;
  int n_fail   = 0;

  draw_playfield #(.FLASH_FRAMES(2)) dut (
    .pclk(pclk), .rst(rst),
    .hcount_in(hcount_in), .vcount_in(vcount_in),
    .hsync_in(hsync_in), .hblnk_in(hblnk_in),
    .vsync_in(vsync_in), .vblnk_in(vblnk_in),
    .grid_en(grid_en), .flash_en(flash_en),
    .hcount_out(hcount_out), .vcount_out(vcount_out),
    .hsync_out(hsync_out), .hblnk_out(hblnk_out),
    .vsync_out(vsync_out), .vblnk_out(vblnk_out),
    .rgb_out(rgb_out), .cell_x(cell_x), .cell_y(cell_y),
    .in_play(in_play), .frame_start(frame_start),
    .play_x0_grid(play_x0_grid), .play_y0_grid(play_y0_grid),
    .play_w_grid(play_w_grid), .play_h_grid(play_h_grid)
  );

  always #5 pclk = ~pclk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge pclk);
    #1;
  endtask

  task automatic set_px(input int h, input int v);
    hcount_in = 11'(h);
    vcount_in = 11'(v);
  endtask

  task automatic check_consts();
    check("play_x0", 32'(play_x0_grid), 32'd13);
    check("play_y0", 32'(play_y0_grid), 32'd15);
    check("play_w",  32'(play_w_grid),  32'd38);
    check("play_h",  32'(play_h_grid),  32'd18);
  endtask

  // One vblnk rising edge, then back to active video; checks the pulse and
  // the resulting border colour at pixel (192,300).
  task automatic vblnk_edge(input string tag, input logic [11:0] exp_border);
    vblnk_in = 1'b1;
    step(1);
    check({tag, "_fs_hi"}, 32'(frame_start), 32'd1);
    step(1);
    check({tag, "_fs_lo"}, 32'(frame_start), 32'd0);
    vblnk_in = 1'b0;
    step(3);
    check({tag, "_border"}, 32'(rgb_out), 32'(exp_border));
  endtask

  initial begin
    rst = 1'b1;
    set_px(500, 400);
    hsync_in = 1'b1; hblnk_in = 1'b0; vsync_in = 1'b1; vblnk_in = 1'b0;
    grid_en = 1'b1; flash_en = 1'b0;
    step(2);
    check("rst_rgb",    32'(rgb_out),     32'h0);
    check("rst_hcount", 32'(hcount_out),  32'h0);
    check("rst_hsync",  32'(hsync_out),   32'h0);
    check("rst_vsync",  32'(vsync_out),   32'h0);
    check("rst_cellx",  32'(cell_x),      32'h0);
    check("rst_inplay", 32'(in_play),     32'h0);
    check("rst_fs",     32'(frame_start), 32'h0);
    check_consts();
    rst = 1'b0;
    hsync_in = 1'b0; vsync_in = 1'b0;

    // Border pixel in IDLE
    set_px(192, 300); grid_en = 1'b0;
    step(2);
    check("border_rgb",   32'(rgb_out), 32'hff0);
    check("border_play",  32'(in_play), 32'd0);
    check("border_cellx", 32'(cell_x),  32'd12);
    check("border_celly", 32'(cell_y),  32'd18);

    // Grid line and interior
    set_px(500, 400); grid_en = 1'b1;
    step(2);
    check("grid_rgb",   32'(rgb_out), 32'h00f);
    check("grid_play",  32'(in_play), 32'd1);
    check("grid_cellx", 32'(cell_x),  32'd31);
    check("grid_celly", 32'(cell_y),  32'd25);
    grid_en = 1'b0;
    step(2);
    check("nogrid_rgb", 32'(rgb_out), 32'hfff);
    set_px(500, 401); grid_en = 1'b1;
    step(2);
    check("offgrid_rgb", 32'(rgb_out), 32'hfff);

    // Outside the outer rectangle, last outer column, first inner column
    set_px(191, 300);
    step(2);
    check("outside_rgb", 32'(rgb_out), 32'hfff);
    set_px(831, 300);
    step(2);
    check("right_edge_rgb", 32'(rgb_out), 32'hff0);
    set_px(208, 241);
    step(2);
    check("inner_left_rgb", 32'(rgb_out), 32'h00f);
    check("inner_left_play", 32'(in_play), 32'd1);

    // Blanking and exact two-cycle latency
    set_px(192, 300);
    step(3);
    set_px(500, 400); hblnk_in = 1'b1; hsync_in = 1'b1;
    step(1);
    check("lat1_rgb", 32'(rgb_out), 32'hff0);
    set_px(192, 300); hblnk_in = 1'b0; hsync_in = 1'b0;
    step(1);
    check("blank_rgb",    32'(rgb_out),    32'h000);
    check("blank_play",   32'(in_play),    32'd0);
    check("blank_hsync",  32'(hsync_out),  32'd1);
    check("blank_hblnk",  32'(hblnk_out),  32'd1);
    check("blank_hcount", 32'(hcount_out), 32'd500);
    step(1);
    check("after_blank_rgb",   32'(rgb_out),    32'hff0);
    check("after_blank_hblnk", 32'(hblnk_out),  32'd0);
    check("after_blank_hcnt",  32'(hcount_out), 32'd192);

    // Flash sequence with FLASH_FRAMES=2
    grid_en = 1'b0; flash_en = 1'b1;
    step(3);
    check("flash_idle", 32'(rgb_out), 32'hff0);
    vblnk_edge("e1", 12'hf00);
    vblnk_edge("e2", 12'hf00);
    vblnk_edge("e3", 12'hfff);
    vblnk_edge("e4", 12'hfff);
    vblnk_edge("e5", 12'hf00);
    flash_en = 1'b0;
    step(3);
    check("flash_off", 32'(rgb_out), 32'hff0);

    // Reset while DARK, released with vblnk held high
    flash_en = 1'b1;
    vblnk_edge("r1", 12'hf00);
    vblnk_edge("r2", 12'hf00);
    vblnk_edge("r3", 12'hfff);
    rst = 1'b1; vblnk_in = 1'b1;
    step(2);
    check("rst2_rgb",    32'(rgb_out),     32'h0);
    check("rst2_vblnk",  32'(vblnk_out),   32'h0);
    check("rst2_vcount", 32'(vcount_out),  32'h0);
    check("rst2_fs",     32'(frame_start), 32'h0);
    check_consts();
    rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      step(1);
      check("release_fs", 32'(frame_start), 32'h0);
    end
    vblnk_in = 1'b0;
    step(3);
    check("release_idle", 32'(rgb_out), 32'hff0);
    vblnk_edge("restart", 12'hf00);
    check_consts();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
